// File: rtl/rx78_cart_loader.sv
// rx78 cartridge upload port: buffers the host ioctl download stream, replays it to the
// core at a fixed pace, then sweeps VRAM and holds the core in reset until done.
module rx78_cart_loader #(
  parameter logic [7:0]  CART_INDEX  = 8'd1,
  parameter logic [7:0]  SWEEP_INDEX = 8'hFF,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PACE        = 2,
  parameter int unsigned MAX_BYTES   = 32768,
  parameter int unsigned SWEEP_LEN   = 8192,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic        ioctl_wait,
  output logic        upload,
  output logic [7:0]  upload_index,
  output logic [24:0] upload_addr,
  output logic [7:0]  upload_data,
  output logic        core_reset,
  output logic [24:0] loaded_size,
  output logic        overflow
);

  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned PACE_W  = $clog2(PACE) + 1;
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES) + 1;

  localparam logic [ADDR_W-1:0] MAX_ADDR    = ADDR_W'(MAX_BYTES);
  localparam logic [ADDR_W-1:0] SWEEP_LAST  = ADDR_W'(SWEEP_LEN - 1);
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(PACE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_SWEEP = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t state, next_state;

  // FIFO storage and control
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count, count_d;
  logic               fifo_empty, fifo_full;
  logic               cart_wr, push, pop, drop;
  logic [ADDR_W-1:0]  head_addr, pop_size;
  logic [DATA_W-1:0]  head_data;

  // Pace / hold counters
  logic [PACE_W-1:0]  pace_cnt, pace_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_d;
  logic               pace_idle;

  // Next values of registered outputs
  logic               ioctl_wait_d, upload_d, core_reset_d, overflow_d;
  logic [7:0]         upload_index_d;
  logic [ADDR_W-1:0]  upload_addr_d, loaded_size_d;
  logic [DATA_W-1:0]  upload_data_d;

  // FIFO push/pop decisions; a full FIFO still accepts when it pops the same cycle
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    pace_idle  = (pace_cnt == '0);
    head_addr  = mem[rd_ptr][ENTRY_W-1:DATA_W];
    head_data  = mem[rd_ptr][DATA_W-1:0];
    pop_size   = (head_addr >= MAX_ADDR) ? MAX_ADDR : head_addr + ADDR_W'(1);
    cart_wr    = ioctl_wr && (ioctl_index == CART_INDEX) && (state == S_LOAD);
    pop        = ((state == S_LOAD) || (state == S_DRAIN)) && !fifo_empty && pace_idle;
    push       = cart_wr && (ioctl_addr < MAX_ADDR) && (!fifo_full || pop);
    drop       = cart_wr && !push;
    case ({push, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (ioctl_download && (ioctl_index == CART_INDEX)) next_state = S_LOAD;
      S_LOAD:  if (!ioctl_download) next_state = S_DRAIN;
      S_DRAIN: if (fifo_empty && pace_idle) next_state = S_SWEEP;
      S_SWEEP: if (pace_idle && (upload_addr == SWEEP_LAST)) next_state = S_HOLD;
      S_HOLD:  if (hold_cnt == HOLD_LAST) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output / datapath next values, keyed on the state being entered
  always_comb begin
    upload_d       = 1'b0;
    upload_index_d = 8'h00;
    core_reset_d   = (next_state != S_IDLE);
    ioctl_wait_d   = (next_state == S_LOAD) && (count_d == FULL_CNT);
    upload_addr_d  = upload_addr;
    upload_data_d  = upload_data;
    loaded_size_d  = loaded_size;
    overflow_d     = overflow;
    pace_d         = pace_idle ? '0 : pace_cnt - PACE_W'(1);
    hold_d         = '0;

    case (next_state)
      S_LOAD, S_DRAIN: begin
        upload_d       = 1'b1;
        upload_index_d = CART_INDEX;
      end
      S_SWEEP: begin
        upload_d       = 1'b1;
        upload_index_d = SWEEP_INDEX;
      end
      default: ;
    endcase

    if ((state == S_IDLE) && (next_state == S_LOAD)) begin
      upload_addr_d = '0;
      upload_data_d = '0;
      loaded_size_d = '0;
      overflow_d    = 1'b0;
    end

    if (drop) overflow_d = 1'b1;

    if (pop) begin
      upload_addr_d = head_addr;
      upload_data_d = head_data;
      pace_d        = PACE_RELOAD;
      if (pop_size > loaded_size) loaded_size_d = pop_size;
    end

    if ((state == S_DRAIN) && (next_state == S_SWEEP)) begin
      upload_addr_d = '0;
      upload_data_d = '0;
      pace_d        = PACE_RELOAD;
    end

    if (state == S_SWEEP) begin
      upload_data_d = '0;
      if (next_state == S_HOLD) begin
        upload_addr_d = '0;
      end else if (pace_idle) begin
        upload_addr_d = upload_addr + ADDR_W'(1);
        pace_d        = PACE_RELOAD;
      end
    end

    if ((state == S_HOLD) && (next_state == S_HOLD)) hold_d = hold_cnt + HOLD_W'(1);
  end

  // Registered outputs and counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ioctl_wait   <= 1'b0;
      upload       <= 1'b0;
      upload_index <= 8'h00;
      upload_addr  <= '0;
      upload_data  <= '0;
      core_reset   <= 1'b0;
      loaded_size  <= '0;
      overflow     <= 1'b0;
      pace_cnt     <= '0;
      hold_cnt     <= '0;
    end else begin
      ioctl_wait   <= ioctl_wait_d;
      upload       <= upload_d;
      upload_index <= upload_index_d;
      upload_addr  <= upload_addr_d;
      upload_data  <= upload_data_d;
      core_reset   <= core_reset_d;
      loaded_size  <= loaded_size_d;
      overflow     <= overflow_d;
      pace_cnt     <= pace_d;
      hold_cnt     <= hold_d;
    end
  end

endmodule

// File: tb/tb_rx78_cart_loader.sv
// Self-checking bench for rx78_cart_loader: vector table for the first download,
// then directed sequences for sweep/hold, back-pressure, overflow, reset and foreign index.
module tb_rx78_cart_loader;

  logic        clk;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic        upload;
  logic [7:0]  upload_index;
  logic [24:0] upload_addr;
  logic [7:0]  upload_data;
  logic        core_reset;
  logic [24:0] loaded_size;
  logic        overflow;

  rx78_cart_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .ioctl_wait     (ioctl_wait),
    .upload         (upload),
    .upload_index   (upload_index),
    .upload_addr    (upload_addr),
    .upload_data    (upload_data),
    .core_reset     (core_reset),
    .loaded_size    (loaded_size),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        dl;
    logic [7:0]  idx;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [43:0] exp;
  } vec_t;

  vec_t tbl [13];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Bus monitor: records each distinct cart pair and how many cycles it was held
  logic        mon_en = 1'b0;
  int          mon_n;
  logic [32:0] mon_key;
  logic [24:0] mon_addr [64];
  logic [7:0]  mon_data [64];
  int          mon_hold [64];

  always @(negedge clk) begin
    if (!mon_en) begin
      mon_n   = 0;
      mon_key = '0;
    end else if (upload && upload_index == 8'h01) begin
      if ({upload_addr, upload_data} != mon_key) begin
        if (mon_n < 64) begin
          mon_addr[mon_n] = upload_addr;
          mon_data[mon_n] = upload_data;
          mon_hold[mon_n] = 1;
        end
        mon_n   = mon_n + 1;
        mon_key = {upload_addr, upload_data};
      end else if (mon_n > 0 && mon_n <= 64) begin
        mon_hold[mon_n-1] = mon_hold[mon_n-1] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [43:0] outs();
    return {upload, upload_index, upload_addr, upload_data, core_reset, ioctl_wait};
  endfunction

  function automatic logic [43:0] ex(input logic up, input logic [7:0] ui, input logic [24:0] ua,
                                     input logic [7:0] ud, input logic cr, input logic w);
    return {up, ui, ua, ud, cr, w};
  endfunction

  function automatic vec_t mk(input logic dl, input logic [7:0] idx, input logic wr,
                              input logic [24:0] addr, input logic [7:0] dout, input logic [43:0] e);
    vec_t v;
    v.dl = dl; v.idx = idx; v.wr = wr; v.addr = addr; v.dout = dout; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic dl, input logic [7:0] idx, input logic wr,
                       input logic [24:0] addr, input logic [7:0] dout);
    ioctl_download = dl;
    ioctl_index    = idx;
    ioctl_wr       = wr;
    ioctl_addr     = addr;
    ioctl_dout     = dout;
  endtask

  task automatic mon_restart();
    mon_en = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int bad;
    int hold_n;
    int sent;
    logic cr_end;
    logic saw_wait;

    // Row k: inputs sampled at the next edge, expected outputs after that edge
    tbl[0]  = mk(1'b1, 8'd1, 1'b0, 25'd0, 8'h00, ex(1'b1, 8'h01, 25'd0, 8'h00, 1'b1, 1'b0));
    tbl[1]  = mk(1'b1, 8'd1, 1'b1, 25'd0, 8'hA0, ex(1'b1, 8'h01, 25'd0, 8'h00, 1'b1, 1'b0));
    tbl[2]  = mk(1'b1, 8'd1, 1'b1, 25'd1, 8'hA1, ex(1'b1, 8'h01, 25'd0, 8'hA0, 1'b1, 1'b0));
    tbl[3]  = mk(1'b1, 8'd1, 1'b1, 25'd2, 8'hA2, ex(1'b1, 8'h01, 25'd0, 8'hA0, 1'b1, 1'b0));
    tbl[4]  = mk(1'b1, 8'd1, 1'b1, 25'd3, 8'hA3, ex(1'b1, 8'h01, 25'd1, 8'hA1, 1'b1, 1'b0));
    tbl[5]  = mk(1'b1, 8'd1, 1'b0, 25'd0, 8'h00, ex(1'b1, 8'h01, 25'd1, 8'hA1, 1'b1, 1'b0));
    tbl[6]  = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, ex(1'b1, 8'h01, 25'd2, 8'hA2, 1'b1, 1'b0));
    tbl[7]  = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, ex(1'b1, 8'h01, 25'd2, 8'hA2, 1'b1, 1'b0));
    tbl[8]  = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, ex(1'b1, 8'h01, 25'd3, 8'hA3, 1'b1, 1'b0));
    tbl[9]  = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, ex(1'b1, 8'h01, 25'd3, 8'hA3, 1'b1, 1'b0));
    tbl[10] = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, ex(1'b1, 8'hFF, 25'd0, 8'h00, 1'b1, 1'b0));
    tbl[11] = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, ex(1'b1, 8'hFF, 25'd0, 8'h00, 1'b1, 1'b0));
    tbl[12] = mk(1'b0, 8'd0, 1'b0, 25'd0, 8'h00, ex(1'b1, 8'hFF, 25'd1, 8'h00, 1'b1, 1'b0));

    // Reset
    reset_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {outs(), loaded_size, overflow}, 70'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // A: 4-byte download vectors through sweep entry
    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].dl, tbl[r].idx, tbl[r].wr, tbl[r].addr, tbl[r].dout);
      @(negedge clk);
      chk($sformatf("a_vec%0d", r), outs(), tbl[r].exp);
    end

    // A: full sweep, a download attempt during it, then the hold window
    bad = 0; hold_n = 0; cr_end = 1'b1;
    for (int c = 3; c <= 16400; c++) begin
      @(negedge clk);
      if (c < 16384) begin
        if (outs() !== ex(1'b1, 8'hFF, 25'(c / 2), 8'h00, 1'b1, 1'b0)) bad++;
      end else if (c < 16400) begin
        if (upload !== 1'b0 || core_reset !== 1'b1) bad++;
        else hold_n++;
      end else begin
        cr_end = core_reset;
      end
      if (c >= 50 && c < 60) drive(1'b1, 8'd1, 1'b1, 25'(c), 8'h77);
      else drive(1'b0, 8'd0, 1'b0, 25'd0, 8'h00);
    end
    chk("a_sweep_seq_errors", bad, 0);
    chk("a_hold_len", hold_n, 16);
    chk("a_core_reset_drop", cr_end, 1'b0);
    chk("a_overflow", overflow, 1'b0);
    chk("a_loaded_size", loaded_size, 25'd4);

    // B: 16 bytes, host honours ioctl_wait
    mon_restart();
    drive(1'b1, 8'd1, 1'b0, 25'd0, 8'h00);
    @(negedge clk);
    sent = 0; saw_wait = 1'b0;
    for (int k = 0; k < 200 && sent < 16; k++) begin
      if (!ioctl_wait) begin
        drive(1'b1, 8'd1, 1'b1, 25'(sent), 8'(8'h10 + sent));
        sent++;
      end else begin
        ioctl_wr = 1'b0;
      end
      @(negedge clk);
      if (ioctl_wait) saw_wait = 1'b1;
    end
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'h00);
    chk("b_bytes_sent", sent, 16);
    chk("b_wait_pulsed", saw_wait, 1'b1);
    for (int k = 0; k < 300 && upload_index !== 8'hFF; k++) @(negedge clk);
    chk("b_drain_to_sweep", upload_index, 8'hFF);
    chk("b_pair_count", mon_n, 16);
    bad = 0;
    for (int j = 0; j < 16; j++)
      if (mon_addr[j] !== 25'(j) || mon_data[j] !== 8'(8'h10 + j) || mon_hold[j] != 2) bad++;
    chk("b_pair_order_hold", bad, 0);
    chk("b_loaded_size", loaded_size, 25'd16);
    chk("b_overflow", overflow, 1'b0);

    // B: reset pulse mid-sweep at address 100
    for (int k = 0; k < 400 && upload_addr !== 25'd100; k++) @(negedge clk);
    chk("b_reach_addr100", upload_addr, 25'd100);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("b_reset_mid_sweep", {outs(), loaded_size, overflow}, 70'd0);
    @(negedge clk);
    chk("b_idle_after_reset", outs(), 44'd0);

    // C: new download ignoring ioctl_wait -> byte 8 dropped, overflow set
    mon_restart();
    drive(1'b1, 8'd1, 1'b0, 25'd0, 8'h00);
    @(negedge clk);
    chk("c_load_entry", {upload, core_reset, upload_index}, {1'b1, 1'b1, 8'h01});
    saw_wait = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'd1, 1'b1, 25'(k), 8'(8'h50 + k));
      @(negedge clk);
      if (ioctl_wait) saw_wait = 1'b1;
    end
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'h00);
    chk("c_wait_seen", saw_wait, 1'b1);
    for (int k = 0; k < 200 && upload_index !== 8'hFF; k++) @(negedge clk);
    chk("c_drain_to_sweep", upload_index, 8'hFF);
    chk("c_overflow_full", overflow, 1'b1);
    chk("c_pair_count", mon_n, 9);
    bad = 0;
    for (int j = 0; j < 8; j++)
      if (mon_addr[j] !== 25'(j) || mon_data[j] !== 8'(8'h50 + j)) bad++;
    if (mon_addr[8] !== 25'd9 || mon_data[8] !== 8'h59) bad++;
    chk("c_pairs", bad, 0);
    chk("c_loaded_size", loaded_size, 25'd10);
    for (int k = 0; k < 20000 && core_reset !== 1'b0; k++) @(negedge clk);
    chk("c_back_to_idle", core_reset, 1'b0);
    chk("c_overflow_sticky", overflow, 1'b1);

    // D: top-of-range bytes; addr 32768 is dropped
    mon_restart();
    drive(1'b1, 8'd1, 1'b0, 25'd0, 8'h00);
    @(negedge clk);
    chk("d_entry_clears", {overflow, loaded_size}, 26'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'd1, 1'b1, 25'(32766 + k), 8'(8'h11 * (k + 1)));
      @(negedge clk);
      ioctl_wr = 1'b0;
      repeat (2) @(negedge clk);
    end
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'h00);
    for (int k = 0; k < 200 && upload_index !== 8'hFF; k++) @(negedge clk);
    chk("d_drain_to_sweep", upload_index, 8'hFF);
    chk("d_overflow_range", overflow, 1'b1);
    chk("d_loaded_size_max", loaded_size, 25'd32768);
    chk("d_pair_count", mon_n, 2);
    chk("d_pairs", {mon_addr[0], mon_data[0], mon_addr[1], mon_data[1]},
        {25'd32766, 8'h11, 25'd32767, 8'h22});
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // E: foreign index download leaves everything quiet
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 8'd2, (k < 8), 25'(k), 8'(8'h30 + k));
      @(negedge clk);
      if (upload !== 1'b0 || core_reset !== 1'b0 || ioctl_wait !== 1'b0) bad++;
    end
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'h00);
    @(negedge clk);
    chk("e_foreign_quiet", bad, 0);
    chk("e_state_untouched", {outs(), loaded_size, overflow}, 70'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
